mmio_data_fifo: RTL
===================

MMIO_DATA_FIFO -- requirements
Module: mmio_data_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, push request, driven by the MMIO write decode (address h0020).
REQ-006 SHALL have port wr_data, input, WIDTH, push data (MMIO write payload [63:0]).
REQ-007 SHALL have port rd_en, input, 1, pop request, driven by the MMIO read decode (address h0020).
REQ-008 SHALL have port rd_data, output, WIDTH, head-of-queue word.
REQ-009 SHALL have port full, output, 1, high when count equals DEPTH.
REQ-010 SHALL have port empty, output, 1, high when count equals 0.
REQ-011 SHALL have port count, output, clog2(DEPTH+1), current occupancy.
REQ-012 SHALL have port err_clr, input, 1, clears the sticky error flags (present only with MMIO_FIFO_ERR_EN).
REQ-013 SHALL have port overflow, output, 1, sticky flag for a dropped push (present only with MMIO_FIFO_ERR_EN).
REQ-014 SHALL have port underflow, output, 1, sticky flag for an ignored pop (present only with MMIO_FIFO_ERR_EN).

Function
REQ-015 SHALL use first-word-fall-through: rd_data equals the oldest stored word whenever empty is low; rd_data SHALL be 0 when empty.
REQ-016 SHALL accept a push when wr_en is high and the FIFO is not full; the word is stored at wr_ptr and wr_ptr advances by 1 on the same edge.
REQ-017 SHALL accept a pop when rd_en is high and the FIFO is not empty; rd_ptr advances by 1 and the next word appears on rd_data in the following cycle.
REQ-018 SHALL wrap both pointers from DEPTH-1 to 0; the pointers are log2(DEPTH) bits wide.
REQ-019 SHALL update count as follows: +1 on push only, -1 on pop only, unchanged on both or neither; full and empty SHALL be derived from the registered count.
REQ-020 SHALL accept both operations when push and pop coincide while full; count stays at DEPTH and no overflow is raised.
REQ-021 SHALL accept only the push when push and pop coincide while empty; the pop is ignored, count becomes 1, and underflow is raised if enabled.
REQ-022 SHALL drop a push while full without a pop; storage, pointers and count are unchanged.
REQ-023 SHALL ignore a pop while empty; pointers and count are unchanged.
REQ-024 SHALL hold data written into storage until it is popped; the overwrite path is limited to accepted pushes.

Reset
REQ-025 SHALL respond asynchronously to rst_n low, forcing wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0, rd_data=0.
REQ-026 SHALL discard all queued data on reset asserted mid-operation; the first push after release appears on rd_data the following cycle.
REQ-027 SHALL NOT require the storage array itself to be reset.

Configuration
REQ-028 With MMIO_FIFO_ERR_EN defined, SHALL implement err_clr, overflow and underflow: a flag sets the cycle after a dropped push or ignored pop, and err_clr clears both flags one cycle later, with a set event taking priority over a clear in the same cycle.
REQ-029 Without MMIO_FIFO_ERR_EN, SHALL omit err_clr, overflow and underflow and their logic entirely; all other behaviour is identical.

Structure
REQ-030 SHALL place the WIDTH and DEPTH defaults, and the pointer and count width typedefs, in the shared package mmio_fifo_pkg.
REQ-031 SHALL use a single sub-module, mmio_fifo_mem: a DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port.

Verification
REQ-032 SHALL cover reset then push 0xA, 0xB, 0xC: rd_data=0xA, count=3, empty=0.
REQ-033 SHALL cover pushing 9 words into an 8-entry FIFO: full=1 after the 8th push, the 9th is dropped, overflow=1, and draining returns the first 8 words in order.
REQ-034 SHALL cover a simultaneous push and pop while full: count stays 8, overflow stays 0, and the popped word is the oldest.
REQ-035 SHALL cover a pop while empty combined with a push of 0x55: underflow=1, count=1, rd_data=0x55; err_clr then clears underflow to 0.
REQ-036 SHALL cover 20 push/pop pairs: pointer wrap with data order preserved and count never exceeding 1.
REQ-037 SHALL cover rst_n low with 5 entries queued: empty=1 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_fifo_pkg.sv
// mmio_fifo_pkg
//   Shared defaults and width typedefs for the MMIO data FIFO slice.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF : default word width and entry count
//   fifo_ptr_t / fifo_cnt_t         : pointer and occupancy types for the defaults
//   ptr_width() / cnt_width()       : width helpers for non-default DEPTH
package mmio_fifo_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 64;
   localparam int unsigned FIFO_DEPTH_DEF = 8;

   localparam int unsigned PTR_W_DEF = $clog2(FIFO_DEPTH_DEF);
   localparam int unsigned CNT_W_DEF = $clog2(FIFO_DEPTH_DEF + 1);

   typedef logic [PTR_W_DEF-1:0] fifo_ptr_t;
   typedef logic [CNT_W_DEF-1:0] fifo_cnt_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/mmio_data_fifo_if.sv
// mmio_data_fifo_if
//   Push/pop/status bundle between the MMIO decode (master) and the FIFO (slave).
//   wr_en, wr_data      : push request and payload
//   rd_en               : pop request
//   rd_data             : head-of-queue word (0 when empty)
//   full, empty, count  : occupancy status
//   err_clr, overflow, underflow : sticky error flags, only with MMIO_FIFO_ERR_EN
interface mmio_data_fifo_if
   import mmio_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
);

   localparam int unsigned CNT_W = cnt_width(DEPTH);

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
`ifdef MMIO_FIFO_ERR_EN
   logic             err_clr;
   logic             overflow;
   logic             underflow;
`endif

   modport master (
      output wr_en, wr_data, rd_en,
`ifdef MMIO_FIFO_ERR_EN
      output err_clr,
      input  overflow, underflow,
`endif
      input  rd_data, full, empty, count
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
`ifdef MMIO_FIFO_ERR_EN
      input  err_clr,
      output overflow, underflow,
`endif
      output rd_data, full, empty, count
   );

endinterface

// File: rtl/mmio_fifo_mem.sv
// mmio_fifo_mem
//   DEPTH x WIDTH register array, synchronous write, asynchronous read.
//   Storage is deliberately not reset; validity is tracked by the FIFO count.
//   clk           : write clock
//   we/waddr/wdata: write port
//   raddr/rdata   : combinational read port
module mmio_fifo_mem
   import mmio_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_data_fifo.sv
// mmio_data_fifo
//   First-word-fall-through data FIFO behind an MMIO data register.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mmio_data_fifo_if.slave (push/pop, data, status)
//   Optional feature macro MMIO_FIFO_ERR_EN adds sticky overflow/underflow
//   flags and their err_clr input; without it those signals do not exist.
module mmio_data_fifo
   import mmio_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input logic              clk,
   input logic              rst_n,
   mmio_data_fifo_if.slave  bus
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned CNT_W = cnt_width(DEPTH);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] mem_rdata;

   logic full_s;
   logic empty_s;
   logic push;
   logic pop;

   assign full_s  = (count_q == CNT_FULL);
   assign empty_s = (count_q == '0);

   // A pop frees a slot in the same edge, so a push while full is accepted
   // whenever it coincides with a pop.
   assign pop  = bus.rd_en & ~empty_s;
   assign push = bus.wr_en & (~full_s | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_q <= count_q - CNT_ONE;
         end
      end
   end

   mmio_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (bus.wr_data),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   // Storage is unreset, so the head word is masked to 0 whenever empty.
   assign bus.rd_data = empty_s ? '0 : mem_rdata;
   assign bus.full    = full_s;
   assign bus.empty   = empty_s;
   assign bus.count   = count_q;

`ifdef MMIO_FIFO_ERR_EN
   logic overflow_q;
   logic underflow_q;
   logic ovf_set;
   logic udf_set;

   assign ovf_set = bus.wr_en & ~push;
   assign udf_set = bus.rd_en & empty_s;

   // Set wins over a same-cycle clear so no error event is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= ovf_set | (overflow_q  & ~bus.err_clr);
         underflow_q <= udf_set | (underflow_q & ~bus.err_clr);
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule
